spi_main: RTL and testbench

Upstream SPI controller that originates the 44-bit command frames consumed by `spi_sub`. It accepts a request (op, address, data) on a valid/ready handshake and serializes it MSB-first on `mosi` under `cs_n`. After a fixed turnaround it captures the 44-bit response from `miso` and returns it on a one-cycle response strobe. It sits between the on-chip command source and the `spi_sub`/register-file pair, sharing `sclk` with them.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_shreg.sv | 30 +++
 rtl/spi_main.sv | 181 ++++++++++++++++++
 tb/tb_spi_main.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame geometry, opcodes and controller state encoding
package spi_pkg;

  localparam int FRAME_W = 44;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 6;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_TURN,
    ST_CAPT,
    ST_REL,
    ST_GAP
  } spi_main_state_e;

endpackage

// File: rtl/spi_shreg.sv
// rtl/spi_shreg.sv - loadable shift register, MSB shifts out, LSB shifts in
// Only the top OUT_W bits are exposed, so each user sees exactly what it consumes.
module spi_shreg #(
  parameter int W     = 8,
  parameter int OUT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     din,
  input  logic             shift,
  input  logic             sin,
  output logic [OUT_W-1:0] q
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], sin};
    end
  end

  assign q = sr[W-1 -: OUT_W];

endmodule

// File: rtl/spi_main.sv
// rtl/spi_main.sv - SPI command-frame controller; SPI_MAIN_ADDR_CHK_EN enables the address-echo check
// FSM and datapath run on the sclk rising edge; cs_n/mosi are re-timed to the falling edge.
module spi_main
  import spi_pkg::*;
#(
  parameter int TURN_CYC = 2,
  parameter int GAP_CYC  = 2
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_data,
  output logic               rsp_valid,
  output logic [FRAME_W-1:0] rsp_frame,
  output logic               rsp_err,
  output logic               cs_n,
  output logic               mosi,
  input  logic               miso
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_TURN  = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GAP_CYC - 1);

  spi_main_state_e    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_load, tx_shift, rx_shift, rsp_fire;
  logic               cs_n_d, mosi_d;
  logic               tx_msb;
  logic [FRAME_W-2:0] rx_q;
  logic [FRAME_W-1:0] rx_frame;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_shift  = 1'b0;
    rsp_fire  = 1'b0;
    req_ready = 1'b0;
    cs_n_d    = 1'b1;
    mosi_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tx_load = 1'b1;
          cnt_d   = CNT_FRAME;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cs_n_d = 1'b0;
        mosi_d = tx_msb;
        if (cnt_q == '0) begin
          cnt_d   = CNT_TURN;
          state_d = ST_TURN;
        end else begin
          tx_shift = 1'b1;
          cnt_d    = cnt_q - CNT_ONE;
        end
      end
      ST_TURN: begin
        cs_n_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = CNT_FRAME;
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CAPT: begin
        cs_n_d = 1'b0;
        // The last bit bypasses the register and lands straight in rsp_frame.
        if (cnt_q == '0) begin
          rsp_fire = 1'b1;
          state_d  = ST_REL;
        end else begin
          rx_shift = 1'b1;
          cnt_d    = cnt_q - CNT_ONE;
        end
      end
      ST_REL: begin
        cnt_d   = CNT_GAP;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  spi_shreg #(.W(FRAME_W), .OUT_W(1)) u_tx_shreg (
    .clk   (sclk),
    .rst_n (rst_n),
    .load  (tx_load),
    .din   ({req_op, req_addr, req_data}),
    .shift (tx_shift),
    .sin   (1'b0),
    .q     (tx_msb)
  );

  spi_shreg #(.W(FRAME_W - 1), .OUT_W(FRAME_W - 1)) u_rx_shreg (
    .clk   (sclk),
    .rst_n (rst_n),
    .load  (1'b0),
    .din   ('0),
    .shift (rx_shift),
    .sin   (miso),
    .q     (rx_q)
  );

  assign rx_frame = {rx_q, miso};

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_frame <= '0;
    end else begin
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_frame <= rx_frame;
      end
    end
  end

`ifdef SPI_MAIN_ADDR_CHK_EN
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (tx_load) begin
        addr_q <= req_addr;
      end
      err_q <= rsp_fire && (rx_frame[DATA_W +: ADDR_W] != addr_q);
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Falling-edge launch gives the sampler a half period of setup on both pins.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n <= 1'b1;
      mosi <= 1'b0;
    end else begin
      cs_n <= cs_n_d;
      mosi <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_main.sv
// tb/tb_spi_main.sv - directed bench for spi_main against a behavioural subordinate and 1024x32 memory
module tb_spi_main;
  import spi_pkg::*;

  logic               sclk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic [1:0]         req_op = 2'b00;
  logic [ADDR_W-1:0]  req_addr = '0;
  logic [DATA_W-1:0]  req_data = '0;
  logic               miso = 1'b0;
  logic               req_ready, rsp_valid, rsp_err, cs_n, mosi;
  logic [FRAME_W-1:0] rsp_frame;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sclk = ~sclk;

  spi_main dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_frame (rsp_frame),
    .rsp_err   (rsp_err),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  // Subordinate model: samples 44 bits, then answers {op, echo addr, data} after two idle edges.
  logic [31:0]        mem [0:1023];
  int                 rcnt = 0;
  logic [FRAME_W-1:0] sub_rx = '0, sub_rsp = '0, sub_last = '0;

  always @(posedge sclk) begin
    if (cs_n) begin
      rcnt = 0;
    end else begin
      if (rcnt < 44) sub_rx = {sub_rx[42:0], mosi};
      rcnt = rcnt + 1;
      if (rcnt == 44) begin
        sub_last = sub_rx;
        if (sub_rx[43:42] == OP_WR) mem[sub_rx[41:32]] = sub_rx[31:0];
        sub_rsp = {sub_rx[43:42],
                   (sub_rx[41:32] == 10'h2AA) ? 10'h155 : sub_rx[41:32],
                   (sub_rx[43:42] == OP_RD) ? mem[sub_rx[41:32]] : sub_rx[31:0]};
      end
    end
  end

  always @(negedge sclk) begin
    if (!cs_n && rcnt >= 46 && rcnt < 90) miso = sub_rsp[89 - rcnt];
    else miso = 1'b0;
  end

  logic [FRAME_W-1:0] r_frame;
  logic               r_err, r_cs_p0, r_cs_n0, r_mosi_n0;
  int                 r_lat, r_vcnt, r_csfall, r_csrise, r_rdy;

  task automatic run_req(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d);
    int w;
    r_lat = -1; r_vcnt = 0; r_csfall = -1; r_csrise = -1; r_rdy = -1;
    r_frame = '0; r_err = 1'b0;
    req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 200) begin @(posedge sclk); #1; w++; end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge sclk); #1;
    req_valid = 1'b0;
    r_cs_p0 = cs_n;
    #5;
    r_cs_n0 = cs_n; r_mosi_n0 = mosi;
    for (int n = 1; n <= 100; n++) begin
      @(posedge sclk); #1;
      if (rsp_valid) begin r_vcnt++; r_lat = n; r_frame = rsp_frame; r_err = rsp_err; end
      if (!cs_n && r_csfall < 0) r_csfall = n;
      if (cs_n && r_csfall > 0 && r_csrise < 0) r_csrise = n;
      if (req_ready && r_rdy < 0) r_rdy = n;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge sclk);
    #1;
    n_cmp++;
    if ({req_ready, cs_n, mosi, rsp_valid, rsp_err} !== 5'b11000) begin
      n_bad++;
      $display("FAIL reset_ctrl: {rdy,cs_n,mosi,vld,err}=%b required 11000",
               {req_ready, cs_n, mosi, rsp_valid, rsp_err});
    end
    n_cmp++;
    if (rsp_frame !== 44'h0) begin
      n_bad++; $display("FAIL reset_frame: got %h required 0", rsp_frame);
    end
    rst_n = 1'b1;
    @(posedge sclk); #1;
  endtask

  task automatic test_loopback;
    logic [43:0] exp;
    run_req(OP_WR, 10'h3FF, 32'hCAFEBABE);
    exp = {OP_WR, 10'h3FF, 32'hCAFEBABE};
    n_cmp++;
    if (sub_last !== exp) begin n_bad++; $display("FAIL lb_tx_frame: got %h required %h", sub_last, exp); end
    n_cmp++;
    if (r_frame[41:32] !== 10'h3FF) begin n_bad++; $display("FAIL lb_wr_echo: got %h required 3ff", r_frame[41:32]); end
    n_cmp++;
    if (r_err !== 1'b0) begin n_bad++; $display("FAIL lb_err: got %b required 0", r_err); end
    run_req(OP_RD, 10'h3FF, 32'h0);
    n_cmp++;
    if (r_frame !== {OP_RD, 10'h3FF, 32'hCAFEBABE}) begin
      n_bad++; $display("FAIL lb_rd_frame: got %h required %h", r_frame, {OP_RD, 10'h3FF, 32'hCAFEBABE});
    end
  endtask

  task automatic test_cycle;
    run_req(2'b10, 10'h0A5, 32'h0F0F1234);
    n_cmp++;
    if ({r_cs_p0, r_cs_n0, r_mosi_n0} !== 3'b101) begin
      n_bad++; $display("FAIL cyc_first_edge: {cs@P0,cs@N0,mosi@N0}=%b required 101", {r_cs_p0, r_cs_n0, r_mosi_n0});
    end
    n_cmp++;
    if (r_csfall !== 1) begin n_bad++; $display("FAIL cyc_cs_fall: got %0d required 1", r_csfall); end
    n_cmp++;
    if (r_lat !== 90 || r_vcnt !== 1) begin
      n_bad++; $display("FAIL cyc_rsp: cycle %0d count %0d required cycle 90 count 1", r_lat, r_vcnt);
    end
    n_cmp++;
    if (r_csrise !== 91) begin n_bad++; $display("FAIL cyc_cs_rise: got %0d required 91", r_csrise); end
    n_cmp++;
    if (r_rdy !== 93) begin n_bad++; $display("FAIL cyc_ready: got %0d required 93", r_rdy); end
    n_cmp++;
    if (r_frame !== {2'b10, 10'h0A5, 32'h0F0F1234}) begin
      n_bad++; $display("FAIL cyc_frame: got %h required %h", r_frame, {2'b10, 10'h0A5, 32'h0F0F1234});
    end
  endtask

  task automatic test_back_to_back;
    int fall2, vcnt;
    bit was_high;
    fall2 = -1; vcnt = 0; was_high = 0;
    req_op = OP_WR; req_addr = 10'h000; req_data = 32'h12345678; req_valid = 1'b1;
    while (!req_ready) begin @(posedge sclk); #1; end
    @(posedge sclk); #1;
    req_addr = 10'h001; req_data = 32'h9ABCDEF0;
    for (int n = 1; n <= 190; n++) begin
      @(posedge sclk); #1;
      if (n == 94) req_valid = 1'b0;
      if (rsp_valid) vcnt++;
      if (n > 1 && cs_n) was_high = 1;
      if (was_high && !cs_n && fall2 < 0) fall2 = n;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (fall2 !== 95) begin n_bad++; $display("FAIL b2b_second_cs_fall: got %0d required 95", fall2); end
    n_cmp++;
    if (vcnt !== 2) begin n_bad++; $display("FAIL b2b_rsp_count: got %0d required 2", vcnt); end
    run_req(OP_RD, 10'h000, 32'h0);
    n_cmp++;
    if (r_frame[31:0] !== 32'h12345678) begin n_bad++; $display("FAIL b2b_rd0: got %h required 12345678", r_frame[31:0]); end
    run_req(OP_RD, 10'h001, 32'h0);
    n_cmp++;
    if (r_frame[31:0] !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL b2b_rd1: got %h required 9abcdef0", r_frame[31:0]); end
  endtask

  task automatic test_reset_mid;
    int vcnt;
    logic pre_mosi;
    vcnt = 0;
    req_op = OP_WR; req_addr = 10'h055; req_data = 32'h11111111; req_valid = 1'b1;
    while (!req_ready) begin @(posedge sclk); #1; end
    @(posedge sclk); #1;
    req_valid = 1'b0;
    repeat (20) begin @(posedge sclk); #1; end
    pre_mosi = mosi;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pre_mosi, cs_n, mosi} !== 3'b110) begin
      n_bad++; $display("FAIL rstmid_async: {mosi_before,cs_n,mosi}=%b required 110", {pre_mosi, cs_n, mosi});
    end
    n_cmp++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL rstmid_state: {rdy,vld}=%b required 10", {req_ready, rsp_valid});
    end
    repeat (3) @(posedge sclk);
    #1; rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin @(posedge sclk); #1; if (rsp_valid) vcnt++; end
    n_cmp++;
    if (vcnt !== 0) begin n_bad++; $display("FAIL rstmid_no_rsp: got %0d pulses required 0", vcnt); end
    run_req(OP_WR, 10'h056, 32'hA5A5A5A5);
    n_cmp++;
    if (r_lat !== 90 || r_frame !== {OP_WR, 10'h056, 32'hA5A5A5A5}) begin
      n_bad++; $display("FAIL rstmid_next: lat %0d frame %h required 90 %h", r_lat, r_frame, {OP_WR, 10'h056, 32'hA5A5A5A5});
    end
  endtask

  task automatic test_addr_chk;
    logic exp_err;
`ifdef SPI_MAIN_ADDR_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_req(OP_WR, 10'h2AA, 32'h0BADF00D);
    n_cmp++;
    if (r_vcnt !== 1 || r_frame !== {OP_WR, 10'h155, 32'h0BADF00D}) begin
      n_bad++; $display("FAIL achk_frame: count %0d frame %h required 1 %h", r_vcnt, r_frame, {OP_WR, 10'h155, 32'h0BADF00D});
    end
    n_cmp++;
    if (r_err !== exp_err) begin n_bad++; $display("FAIL achk_err: got %b required %b", r_err, exp_err); end
    n_cmp++;
    if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL achk_err_clear: got %b required 0", rsp_err); end
  endtask

  task automatic test_backpressure;
    int viol, vcnt;
    logic [43:0] frame_a, frame_b, last_rsp, sub_at_92;
    viol = 0; vcnt = 0; last_rsp = '0; sub_at_92 = '0;
    frame_a = {OP_WR, 10'h100, 32'h13572468};
    frame_b = {OP_WR, 10'h200, 32'h2468ACE0};
    req_op = OP_WR; req_addr = 10'h100; req_data = 32'h13572468; req_valid = 1'b1;
    while (!req_ready) begin @(posedge sclk); #1; end
    @(posedge sclk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 190; n++) begin
      @(posedge sclk); #1;
      if (n == 50) begin req_addr = 10'h200; req_data = 32'h2468ACE0; req_valid = 1'b1; end
      if (n >= 50 && n <= 92 && req_ready) viol++;
      if (n == 92) sub_at_92 = sub_last;
      if (n == 94) req_valid = 1'b0;
      if (rsp_valid) begin vcnt++; last_rsp = rsp_frame; end
    end
    n_cmp++;
    if (viol !== 0) begin n_bad++; $display("FAIL bp_ready_low: got %0d cycles high required 0", viol); end
    n_cmp++;
    if (sub_at_92 !== frame_a) begin n_bad++; $display("FAIL bp_first_frame: got %h required %h", sub_at_92, frame_a); end
    n_cmp++;
    if (sub_last !== frame_b || last_rsp !== frame_b || vcnt !== 2) begin
      n_bad++; $display("FAIL bp_second_frame: tx %h rsp %h count %0d required %h %h 2", sub_last, last_rsp, vcnt, frame_b, frame_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_loopback();
    test_cycle();
    test_back_to_back();
    test_reset_mid();
    test_addr_chk();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
